// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings for the multi-channel PWM core.
package pwm_pkg;
    typedef enum logic [1:0] {CNT_UP = 2'b00, CNT_DOWN = 2'b01, CNT_CENTER = 2'b10} cnt_mode_t;
    typedef enum logic [1:0] {FN_LEFT = 2'b00, FN_RIGHT = 2'b01, FN_WINDOW = 2'b10, FN_RSVD = 2'b11} fn_t;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output pair with rising-edge dead-time insertion.
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            r,
    input  logic [DT_W-1:0] deadtime,
    output logic            hi,
    output logic            lo
);
    localparam logic [DT_W-1:0] DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};
    logic [DT_W-1:0] hcnt, lcnt;
    // Each counter holds how many consecutive enabled cycles its side has been asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            hcnt <= !(en && r) ? '0 : &hcnt ? hcnt : hcnt + DT_ONE;
            lcnt <= !(en && !r) ? '0 : &lcnt ? lcnt : lcnt + DT_ONE;
        end
    end
    assign hi = !rst && en && r && hcnt >= deadtime;
    assign lo = !rst && en && !r && lcnt >= deadtime;
endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: shared prescaled up/down/centre timebase driving NUM_CH
// double-buffered PWM channels with complementary dead-time outputs.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int DT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    count_reset,
    input  logic [1:0]              cnt_mode,
    input  logic [7:0]              prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] cmp1,
    input  logic [NUM_CH*CNT_W-1:0] cmp2,
    input  logic [NUM_CH*2-1:0]     func,
    input  logic [DT_W-1:0]         deadtime,
    input  logic                    update_req,
    output logic [CNT_W-1:0]        count_val,
    output logic                    period_evt,
    output logic                    update_done,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH-1:0]       pwm_out_n
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [7:0] psc;
    logic dir_up, dir_nxt, pending, tick, at_end, load, is_down, is_ctr;
    logic [CNT_W-1:0] per_sh, new_per, cnt_nxt;
    logic [NUM_CH*CNT_W-1:0] c1_sh, c2_sh;
    logic [NUM_CH*2-1:0] fn_sh;

    assign is_down = cnt_mode == CNT_DOWN;
    assign is_ctr = cnt_mode == CNT_CENTER;
    assign tick = en && psc == prescale;
    assign at_end = per_sh == '0 || (is_down ? count_val == '0 :
                    is_ctr ? (count_val == '0 && !dir_up) : count_val == per_sh);
    assign period_evt = !rst && tick && !count_reset && at_end;
    assign load = count_reset || (period_evt && (pending || update_req));
    assign new_per = load ? period : per_sh;

    always_comb begin
        cnt_nxt = count_val;
        dir_nxt = dir_up;
        if (is_ctr) begin
            if (per_sh == '0) begin
                cnt_nxt = '0;
                dir_nxt = 1'b1;
            end else if (dir_up) begin
                cnt_nxt = count_val >= per_sh ? per_sh - ONE : count_val + ONE;
                dir_nxt = count_val < per_sh;
            end else begin
                cnt_nxt = count_val == '0 ? ONE : count_val - ONE;
                dir_nxt = count_val == '0;
            end
        end else if (is_down) begin
            cnt_nxt = count_val == '0 ? new_per : count_val - ONE;
        end else begin
            cnt_nxt = count_val == per_sh ? '0 : count_val + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
            count_val <= '0;
            dir_up <= 1'b1;
            pending <= 1'b0;
            update_done <= 1'b0;
            per_sh <= '0;
            c1_sh <= '0;
            c2_sh <= '0;
            fn_sh <= '0;
        end else begin
            update_done <= load;
            pending <= !load && (pending || update_req);
            if (load) begin
                per_sh <= period;
                c1_sh <= cmp1;
                c2_sh <= cmp2;
                fn_sh <= func;
            end
            if (count_reset) begin
                psc <= '0;
                dir_up <= 1'b1;
                count_val <= is_down ? period : '0;
            end else if (en) begin
                psc <= tick ? '0 : psc + 8'd1;
                if (tick) begin
                    count_val <= cnt_nxt;
                    dir_up <= dir_nxt;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] c1, c2;
        logic [1:0] fn;
        logic raw, r;
        assign c1 = c1_sh[i*CNT_W +: CNT_W];
        assign c2 = c2_sh[i*CNT_W +: CNT_W];
        assign fn = fn_sh[i*2 +: 2];
        // A window with c2 <= c1 has no count satisfying both bounds, so it stays low.
        assign raw = fn == FN_LEFT ? count_val < c1 :
                     fn == FN_RIGHT ? count_val >= c1 :
                     fn == FN_WINDOW ? (count_val >= c1 && count_val < c2) : 1'b0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r <= 1'b0;
            else r <= raw;
        end
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk(clk),
            .rst(rst),
            .en(ch_en[i]),
            .r(r),
            .deadtime(deadtime),
            .hi(pwm_out[i]),
            .lo(pwm_out_n[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: table-driven configurations plus a cycle scoreboard fed by a
// behavioural reference model of pwm_multi_gen.
module tb_pwm_multi_gen;
    localparam int N = 4, W = 16, D = 8;
    logic clk = 0, rst = 1, en = 0, count_reset = 0, update_req = 0;
    logic [1:0] cnt_mode = 0;
    logic [7:0] prescale = 0;
    logic [W-1:0] period = 0;
    logic [N-1:0] ch_en = 0;
    logic [N*W-1:0] cmp1 = 0, cmp2 = 0;
    logic [N*2-1:0] func = 0;
    logic [D-1:0] deadtime = 0;
    logic [W-1:0] count_val;
    logic period_evt, update_done;
    logic [N-1:0] pwm_out, pwm_out_n;
    int checks = 0, failures = 0;
    int hi_n, lo_n, evt_n;
    bit win = 0;

    pwm_multi_gen #(.NUM_CH(N), .CNT_W(W), .DT_W(D)) dut (
        .clk(clk), .rst(rst), .en(en), .count_reset(count_reset), .cnt_mode(cnt_mode),
        .prescale(prescale), .period(period), .ch_en(ch_en), .cmp1(cmp1), .cmp2(cmp2),
        .func(func), .deadtime(deadtime), .update_req(update_req), .count_val(count_val),
        .period_evt(period_evt), .update_done(update_done), .pwm_out(pwm_out), .pwm_out_n(pwm_out_n)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, act, want, $time);
        end
    endfunction

    // Reference model state: what the core should hold during the current cycle.
    int m_cnt = 0, m_psc = 0, m_per = 0;
    bit m_up = 1, m_pend = 0, m_upd = 0;
    int m_c1[N], m_c2[N], m_hrun[N], m_lrun[N];
    bit [1:0] m_fn[N];
    bit m_r[N];

    function automatic bit m_evt();
        if (rst || !en || count_reset || m_psc != int'(prescale)) return 0;
        if (m_per == 0) return 1;
        if (cnt_mode == 2'b01) return m_cnt == 0;
        if (cnt_mode == 2'b10) return m_cnt == 0 && !m_up;
        return m_cnt == m_per;
    endfunction

    function automatic bit raw(int i);
        case (m_fn[i])
            2'd0: return m_cnt < m_c1[i];
            2'd1: return m_cnt >= m_c1[i];
            2'd2: return m_cnt >= m_c1[i] && m_cnt < m_c2[i];
            default: return 0;
        endcase
    endfunction

    function automatic void advance(int p);
        if (cnt_mode == 2'b01) m_cnt = (m_cnt == 0) ? p : m_cnt - 1;
        else if (cnt_mode == 2'b10) begin
            if (m_per == 0) begin m_cnt = 0; m_up = 1; end
            else if (m_up) begin
                if (m_cnt == m_per) begin m_up = 0; m_cnt = m_cnt - 1; end
                else m_cnt = m_cnt + 1;
            end else if (m_cnt == 0) begin m_up = 1; m_cnt = 1; end
            else m_cnt = m_cnt - 1;
        end else m_cnt = (m_cnt == m_per) ? 0 : m_cnt + 1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit ev, ld;
        int np;
        if (rst) begin
            m_cnt = 0; m_psc = 0; m_per = 0; m_up = 1; m_pend = 0; m_upd = 0;
            for (int i = 0; i < N; i++) begin
                m_c1[i] = 0; m_c2[i] = 0; m_fn[i] = 0; m_r[i] = 0; m_hrun[i] = 0; m_lrun[i] = 0;
            end
        end else begin
            ev = m_evt();
            ld = count_reset || (ev && (m_pend || update_req));
            np = ld ? int'(period) : m_per;
            for (int i = 0; i < N; i++) begin
                m_hrun[i] = (ch_en[i] && m_r[i]) ? m_hrun[i] + 1 : 0;
                m_lrun[i] = (ch_en[i] && !m_r[i]) ? m_lrun[i] + 1 : 0;
                m_r[i] = raw(i);
            end
            if (count_reset) begin
                m_cnt = (cnt_mode == 2'b01) ? int'(period) : 0; m_psc = 0; m_up = 1;
            end else if (en && m_psc == int'(prescale)) begin
                m_psc = 0; advance(np);
            end else if (en) m_psc = m_psc + 1;
            m_upd = ld;
            m_pend = !ld && (m_pend || update_req);
            if (ld) begin
                m_per = int'(period);
                for (int i = 0; i < N; i++) begin
                    m_c1[i] = int'(cmp1[i*W +: W]);
                    m_c2[i] = int'(cmp2[i*W +: W]);
                    m_fn[i] = func[i*2 +: 2];
                end
            end
        end
    end

    typedef struct {int cnt; bit evt; bit upd; bit [N-1:0] hi; bit [N-1:0] lo;} exp_t;
    exp_t sbq[$];

    // Push this cycle's expectation (inputs already applied), then move to the next cycle.
    task automatic step();
        exp_t e;
        e.cnt = m_cnt; e.evt = m_evt(); e.upd = m_upd;
        for (int i = 0; i < N; i++) begin
            e.hi[i] = !rst && ch_en[i] && m_r[i] && m_hrun[i] >= int'(deadtime);
            e.lo[i] = !rst && ch_en[i] && !m_r[i] && m_lrun[i] >= int'(deadtime);
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) if (sbq.size() != 0) begin : mon
        exp_t e;
        e = sbq.pop_front();
        chk("count_val", int'(count_val), e.cnt);
        chk("period_evt", int'(period_evt), int'(e.evt));
        chk("update_done", int'(update_done), int'(e.upd));
        chk("pwm_out", int'(pwm_out), int'(e.hi));
        chk("pwm_out_n", int'(pwm_out_n), int'(e.lo));
        chk("no_overlap", int'(pwm_out & pwm_out_n), 0);
        if (win) begin
            hi_n += int'(pwm_out[0]);
            lo_n += int'(pwm_out_n[0]);
            evt_n += int'(period_evt);
        end
    end

    task automatic wait_evt(input string n);
        bit hit = 0;
        for (int k = 0; k < 64 && !hit; k++) begin
            if (period_evt) hit = 1;
            else step();
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s got=no_period_evt want=period_evt", n);
        end
    endtask

    typedef struct {
        bit [1:0] mode; bit [7:0] ps; int per; bit [1:0] fn;
        int c1, c2, dt, win, hi, lo, evt;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        //          mode  ps   per fn   c1 c2 dt win  hi  lo evt
        tbl[0]  = '{2'd0, 8'd0, 9, 2'd0, 3, 0, 0, 20,  6, 14,  2};
        tbl[1]  = '{2'd0, 8'd0, 9, 2'd1, 3, 0, 0, 20, 14,  6,  2};
        tbl[2]  = '{2'd0, 8'd0, 9, 2'd2, 2, 6, 0, 20,  8, 12,  2};
        tbl[3]  = '{2'd0, 8'd0, 9, 2'd2, 6, 2, 0, 20,  0, 20,  2};
        tbl[4]  = '{2'd0, 8'd0, 9, 2'd0, 0, 0, 0, 20,  0, 20,  2};
        tbl[5]  = '{2'd0, 8'd0, 9, 2'd0, 12, 0, 0, 20, 20, 0,  2};
        tbl[6]  = '{2'd0, 8'd0, 9, 2'd3, 3, 6, 0, 20,  0, 20,  2};
        tbl[7]  = '{2'd0, 8'd0, 9, 2'd0, 5, 0, 3, 20,  4,  4,  2};
        tbl[8]  = '{2'd0, 8'd0, 9, 2'd0, 2, 0, 3, 20,  0, 10,  2};
        tbl[9]  = '{2'd1, 8'd0, 9, 2'd0, 3, 0, 0, 20,  6, 14,  2};
        tbl[10] = '{2'd2, 8'd1, 4, 2'd0, 2, 0, 0, 32, 12, 20,  2};
        tbl[11] = '{2'd0, 8'd2, 0, 2'd0, 1, 0, 0, 30, 30,  0, 10};
        tbl[12] = '{2'd3, 8'd1, 9, 2'd0, 3, 0, 0, 40, 12, 28,  2};

        @(posedge clk);
        #2;
        chk("rst_count", int'(count_val), 0);
        chk("rst_outs", int'({pwm_out, pwm_out_n}), 0);
        chk("rst_evt", int'(period_evt), 0);
        chk("rst_upd", int'(update_done), 0);
        repeat (2) step();
        rst = 0; en = 1; ch_en = '1;
        step();

        foreach (tbl[k]) begin
            cnt_mode = tbl[k].mode; prescale = tbl[k].ps;
            period = W'(tbl[k].per); deadtime = D'(tbl[k].dt);
            func = {2'b00, 2'b10, 2'b01, tbl[k].fn};
            cmp1 = {16'd7, 16'd1, 16'd5, 16'(tbl[k].c1)};
            cmp2 = {16'd0, 16'd4, 16'd0, 16'(tbl[k].c2)};
            count_reset = 1; step(); count_reset = 0;
            repeat (tbl[k].win) step();
            hi_n = 0; lo_n = 0; evt_n = 0; win = 1;
            repeat (tbl[k].win) step();
            win = 0;
            chk($sformatf("tbl%0d_hi", k), hi_n, tbl[k].hi);
            chk($sformatf("tbl%0d_lo", k), lo_n, tbl[k].lo);
            chk($sformatf("tbl%0d_evt", k), evt_n, tbl[k].evt);
        end

        cnt_mode = 0; prescale = 0; period = 9; deadtime = 0;
        func = {2'b00, 2'b10, 2'b01, 2'b00};
        cmp1 = {16'd7, 16'd1, 16'd5, 16'd3};
        cmp2 = {16'd0, 16'd4, 16'd0, 16'd0};
        count_reset = 1; step(); count_reset = 0;
        for (int k = 0; k < 40 && m_cnt != 5; k++) step();
        period = 4; update_req = 1; step(); update_req = 0;
        wait_evt("upd_wrap");
        chk("upd_wrap_cnt", int'(count_val), 9);
        chk("upd_not_yet", int'(update_done), 0);
        step();
        chk("upd_done", int'(update_done), 1);
        chk("upd_restart", int'(count_val), 0);
        wait_evt("upd_newp");
        chk("upd_newp_cnt", int'(count_val), 4);

        period = 6; count_reset = 1; step(); count_reset = 0;
        chk("cr_cnt", int'(count_val), 0);
        chk("cr_upd", int'(update_done), 1);
        step();
        chk("cr_run", int'(count_val), 1);
        wait_evt("cr_evt");
        chk("cr_evt_cnt", int'(count_val), 6);

        deadtime = 3; ch_en = 4'b0101; step(); step();
        chk("dis_out", int'({pwm_out[3], pwm_out[1], pwm_out_n[3], pwm_out_n[1]}), 0);
        repeat (12) step();
        ch_en = '1; step();
        chk("reen_dt", int'({pwm_out[1], pwm_out_n[1]}), 0);
        repeat (20) step();

        deadtime = 0; period = 9; count_reset = 1; step(); count_reset = 0;
        for (int k = 0; k < 40 && m_cnt != 7; k++) step();
        rst = 1;
        #1;
        chk("rstmid_cnt", int'(count_val), 0);
        chk("rstmid_outs", int'({pwm_out, pwm_out_n}), 0);
        chk("rstmid_evt", int'(period_evt), 0);
        chk("rstmid_upd", int'(update_done), 0);
        step(); step();
        rst = 0;
        repeat (5) step();
        count_reset = 1; step(); count_reset = 0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Next-generation PWM core that replaces the single counter and single PWM generator pair. It provides one shared prescaled timebase (up, down or centre-aligned) driving NUM_CH independent channels. Each channel has double-buffered compare/function registers and complementary outputs with programmable dead-time. It sits behind the register block, which drives its configuration inputs.

Parameters:
NUM_CH, 4, number of PWM channels
CNT_W, 16, counter, period and compare width
DT_W, 8, dead-time counter width

Ports:
clk  in  1  peripheral clock
rst  in  1  reset; asynchronous, active-high
en  in  1  timebase enable
count_reset  in  1  synchronous counter clear; forces shadow load
cnt_mode  in  2  00 up, 01 down, 10 centre (up/down), 11 treated as up
prescale  in  8  tick every prescale+1 clk cycles
period  in  CNT_W  period value for the shadow register
ch_en  in  NUM_CH  per-channel enable
cmp1  in  NUM_CH*CNT_W  compare 1 per channel; channel i at [i*CNT_W +: CNT_W]
cmp2  in  NUM_CH*CNT_W  compare 2 per channel
func  in  NUM_CH*2  per-channel function
deadtime  in  DT_W  dead-time in clk cycles, shared by all channels
update_req  in  1  one-cycle request to load shadows at the next period event
count_val  out  CNT_W  current counter value
period_evt  out  1  one-cycle pulse at the period boundary
update_done  out  1  one-cycle pulse the cycle after a shadow load
pwm_out  out  NUM_CH  high-side outputs
pwm_out_n  out  NUM_CH  complementary low-side outputs

Behaviour:
- Reset: count_val=0, direction=up, prescaler=0, all shadows=0, update pending=0, all outputs 0.
- Prescaler: counts 0..prescale. A tick is asserted when it equals prescale, then it clears. The counter moves only on a tick. en=0 freezes the counter and the prescaler.
- Up mode: 0,1,..,P,0. Down mode: P,..,0,P. Centre mode: 0..P then P-1..0, repeating; the direction flips at P and at 0. P is the active (shadow) period.
- period_evt: asserted in the cycle the counter wraps. Up mode: tick with count=P. Down mode: tick with count=0. Centre mode: tick with count=0 while counting down.
- P=0: count stays 0 and period_evt pulses on every tick.
- update_req sets a sticky pending flag. At period_evt with pending set: load period, cmp1, cmp2 and func into the shadows, clear pending, and pulse update_done the next cycle. update_req coincident with period_evt loads in that same event.
- count_reset (priority over en): count=0 (down mode: count=period input), prescaler=0, direction=up, unconditional shadow load, pending cleared, update_done pulses.
- Raw channel signal r, registered; latency is 1 clk from count_val:
  - func 00 left-aligned: r = count < C1.
  - func 01 right-aligned: r = count >= C1.
  - func 10 window: r = C1 <= count < C2; C2 <= C1 gives constant 0.
  - func 11 reserved: r = 0.
- Compare boundaries: C1=0 with func 00 gives always 0; C1>P with func 00 gives always 1.
- Dead-time per channel: pwm_out rises only after r has been 1 for deadtime consecutive cycles, and falls in the same cycle r falls. pwm_out_n is the same rule applied to ~r.
  - deadtime=0: outputs are r and ~r.
  - A glitch shorter than deadtime produces no output pulse.
  - pwm_out and pwm_out_n are never both 1.
- ch_en=0: both outputs of that channel are 0 and the dead-time counter clears. On re-enable the channel applies the full dead-time before either output rises.
- Async rst mid-period: everything returns to reset values immediately. Counting resumes from 0 after rst deasserts and en=1.

Decomposition:
- Shared package pwm_pkg: cnt_mode encodings (CNT_UP, CNT_DOWN, CNT_CENTER) and func encodings (FN_LEFT, FN_RIGHT, FN_WINDOW, FN_RSVD).
- Sub-module pwm_deadtime (params DT_W): inputs clk, rst, en, r, deadtime; outputs hi, lo. Instantiated NUM_CH times by generate. Timebase and shadow logic stay in the top module.

Test Plan:
- Up mode, prescale=0, period=9, ch0 func 00, cmp1=3, deadtime=0: pwm_out[0] high 3 of every 10 clocks, pwm_out_n[0] is its complement, period_evt every 10 clocks.
- Centre mode, period=4, prescale=1: count sequence 0,0,1,1,2,2,3,3,4,4,3,3,..,0,0. period_evt once every 16 clocks, at the bottom.
- Shadow update: running up mode with period=9, write period=4 and update_req mid-period. The old period completes, count wraps at 9, the new cycle runs 0..4, and update_done pulses one cycle after the wrap period_evt.
- Dead-time=3, func 00, cmp1=5, period=9: pwm_out rises 3 clk after r rises, pwm_out_n rises 3 clk after r falls, never both 1. A 2-cycle r pulse (cmp1=2, deadtime=3) gives pwm_out constantly 0.
- Window func 10 with cmp1=2, cmp2=6 gives high for counts 2..5. cmp1=6, cmp2=2 gives constant 0. Channels 0..3 with different funcs run simultaneously and independently.
- Assert rst mid-count at count=7: all outputs immediately 0. Also check count_reset with en=1: count goes to 0 and the shadow load is immediate.
